// File: rtl/latch_free_ifetch_if.sv
// rtl/latch_free_ifetch_if.sv - fetch unit bus: instruction memory, redirect and decoder handshakes
interface latch_free_ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/latch_free_ifetch.sv
// rtl/latch_free_ifetch.sv - single-outstanding instruction fetch with prefetch FIFO and redirect flush
module latch_free_ifetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  latch_free_ifetch_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_req, w_push, w_pop, w_valid;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && bus.instr_ready && !bus.redirect_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  // A new request only issues from IDLE with room, so an ack always finds a free slot.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req          = 1'b0;
    w_push         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.redirect_valid && (r_count < C_DEPTH)) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_req = 1'b1;
        if (bus.imem_ack) begin
          w_state_nxt = S_IDLE;
          if (!bus.redirect_valid) begin
            w_push         = 1'b1;
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          end
        end else if (bus.redirect_valid) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        w_req = 1'b1;
        if (bus.imem_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.redirect_valid) w_fetch_pc_nxt = {bus.redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instruction = w_valid ? r_mem_instr[r_rd_ptr] : 32'h0;
  assign bus.instr_pc    = w_valid ? r_mem_pc[r_rd_ptr]    : 32'h0;
endmodule

// File: tb/tb_latch_free_ifetch.sv
// tb/tb_latch_free_ifetch.sv - vector table, corner sequences and random model check for latch_free_ifetch
module tb_latch_free_ifetch;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  latch_free_ifetch_if bus();
  latch_free_ifetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic [97:0] exp;
  } vec_t;
  vec_t vecs[13];

  bit          m_out, m_drop;
  logic [31:0] m_pc;
  logic [63:0] m_q[$];

  function automatic logic [97:0] pack(input logic req, input logic [31:0] addr, input logic v,
                                       input logic [31:0] pc, input logic [31:0] ins);
    return {req, addr, v, pc, ins};
  endfunction

  function automatic logic [97:0] outs();
    return {bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr_pc, bus.instruction};
  endfunction

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic ack,
                              input logic [31:0] rdata, input logic ready, input logic [97:0] exp);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.ack = ack; v.rdata = rdata; v.ready = ready; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [97:0] act, input logic [97:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h instr=%h, expected req=%0b addr=%h valid=%0b pc=%h instr=%h",
               name, act[97], act[96:65], act[64], act[63:32], act[31:0],
               exp[97], exp[96:65], exp[64], exp[63:32], exp[31:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    tick();
    tick();
    check("reset_state", outs(), pack(1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
    reset = 1'b0;
  endtask

  // Memory responder: acks in the first cycle a request is seen, data = 0xA + address.
  task automatic run_auto(input int n, input logic rdy);
    for (int k = 0; k < n; k++) begin
      bus.imem_ack    = bus.imem_req;
      bus.imem_rdata  = 32'hA + bus.imem_addr;
      bus.instr_ready = rdy;
      tick();
    end
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();

    vecs[0]  = mk(0, 0,        0, 0,         1, pack(1, 32'h0,   0, 32'h0,   32'h0));
    vecs[1]  = mk(0, 0,        1, 32'hA,     1, pack(0, 32'h4,   1, 32'h0,   32'hA));
    vecs[2]  = mk(0, 0,        0, 0,         1, pack(1, 32'h4,   0, 32'h0,   32'h0));
    vecs[3]  = mk(0, 0,        1, 32'hE,     1, pack(0, 32'h8,   1, 32'h4,   32'hE));
    vecs[4]  = mk(0, 0,        0, 0,         1, pack(1, 32'h8,   0, 32'h0,   32'h0));
    vecs[5]  = mk(0, 0,        1, 32'h12,    1, pack(0, 32'hC,   1, 32'h8,   32'h12));
    vecs[6]  = mk(0, 0,        0, 0,         1, pack(1, 32'hC,   0, 32'h0,   32'h0));
    vecs[7]  = mk(0, 0,        1, 32'h16,    1, pack(0, 32'h10,  1, 32'hC,   32'h16));
    vecs[8]  = mk(0, 0,        0, 0,         0, pack(1, 32'h10,  1, 32'hC,   32'h16));
    vecs[9]  = mk(1, 32'h103,  0, 0,         0, pack(1, 32'h100, 0, 32'h0,   32'h0));
    vecs[10] = mk(0, 0,        1, 32'hDEAD,  0, pack(0, 32'h100, 0, 32'h0,   32'h0));
    vecs[11] = mk(0, 0,        0, 0,         0, pack(1, 32'h100, 0, 32'h0,   32'h0));
    vecs[12] = mk(0, 0,        1, 32'h10A,   0, pack(0, 32'h104, 1, 32'h100, 32'h10A));

    // Stream and redirect-in-WAIT vectors
    do_reset();
    for (int i = 0; i < 13; i++) begin
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc    = vecs[i].rpc;
      bus.imem_ack       = vecs[i].ack;
      bus.imem_rdata     = vecs[i].rdata;
      bus.instr_ready    = vecs[i].ready;
      tick();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    clear_in();

    // Full FIFO stalls requests; one pop lets the next fetch go to 16
    do_reset();
    run_auto(16, 1'b0);
    check("full_stall", outs(), pack(0, 32'h10, 1, 32'h0, 32'hA));
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("full_pop", outs(), pack(0, 32'h10, 1, 32'h4, 32'hE));
    tick();
    check("full_refill", outs(), pack(1, 32'h10, 1, 32'h4, 32'hE));

    // Redirect with same-cycle ack and pop while two entries are queued
    do_reset();
    run_auto(4, 1'b0);
    tick();
    check("two_entry_wait", outs(), pack(1, 32'h8, 1, 32'h0, 32'hA));
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    bus.imem_ack       = 1'b1;
    bus.imem_rdata     = 32'hDEADBEEF;
    bus.instr_ready    = 1'b1;
    tick();
    clear_in();
    check("redir_ack_pop", outs(), pack(0, 32'h200, 0, 32'h0, 32'h0));
    tick();
    check("redir_next_fetch", outs(), pack(1, 32'h200, 0, 32'h0, 32'h0));
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1234;
    tick();
    clear_in();
    check("redir_target_data", outs(), pack(0, 32'h204, 1, 32'h200, 32'h1234));

    // Address wrap at the top of memory
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFFFFFC;
    tick();
    clear_in();
    check("wrap_redir_idle", outs(), pack(0, 32'hFFFFFFFC, 0, 32'h0, 32'h0));
    run_auto(4, 1'b0);
    check("wrap_first", outs(), pack(0, 32'h4, 1, 32'hFFFFFFFC, 32'h6));
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("wrap_second", outs(), pack(1, 32'h4, 1, 32'h0, 32'hA));

    // Reset asserted while a request is outstanding
    do_reset();
    run_auto(2, 1'b0);
    tick();
    check("pre_reset_wait", outs(), pack(1, 32'h4, 1, 32'h0, 32'hA));
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h55;
    reset = 1'b1;
    #1;
    check("reset_async", outs(), pack(0, 32'h0, 0, 32'h0, 32'h0));
    tick();
    tick();
    check("reset_hold_ack", outs(), pack(0, 32'h0, 0, 32'h0, 32'h0));
    reset = 1'b0;
    clear_in();
    tick();
    check("reset_restart", outs(), pack(1, 32'h0, 0, 32'h0, 32'h0));

    // Random traffic against a queue-based reference
    do_reset();
    m_out = 1'b0; m_drop = 1'b0; m_pc = 32'h0; m_q.delete();
    for (int c = 0; c < 1500; c++) begin
      logic        redir, ack, rdy, do_push, issue;
      logic [31:0] rpc, rdata;
      int          old_size;
      redir = ($urandom_range(15) == 0);
      rpc   = $urandom;
      ack   = 1'($urandom_range(1));
      rdata = $urandom;
      rdy   = 1'($urandom_range(1));
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      bus.imem_ack       = ack;
      bus.imem_rdata     = rdata;
      bus.instr_ready    = rdy;

      old_size = m_q.size();
      do_push  = 1'b0;
      if (redir) begin
        m_q.delete();
        m_pc = {rpc[31:2], 2'b00};
        if (m_out) begin
          if (ack) begin m_out = 1'b0; m_drop = 1'b0; end
          else m_drop = 1'b1;
        end
      end else begin
        issue = !m_out && (old_size < DEPTH);
        if (m_out && ack) begin
          if (!m_drop) do_push = 1'b1;
          m_out  = 1'b0;
          m_drop = 1'b0;
        end
        if (old_size != 0 && rdy) void'(m_q.pop_front());
        if (do_push) begin
          m_q.push_back({m_pc, rdata});
          m_pc = m_pc + 32'd4;
        end
        if (issue) m_out = 1'b1;
      end

      tick();
      if (m_q.size() != 0)
        check("random", outs(), pack(m_out, m_pc, 1'b1, m_q[0][63:32], m_q[0][31:0]));
      else
        check("random", outs(), pack(m_out, m_pc, 1'b0, 32'h0, 32'h0));
    end
    clear_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/latch_free_ifetch.md
LATCH_FREE_IFETCH -- requirements
Module: latch_free_ifetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the prefetch FIFO entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch address (word aligned).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port imem_req, output, 1 bit: instruction-memory read request.
REQ-006 Port imem_addr, output, 32 bits: word-aligned read address.
REQ-007 Port imem_ack, input, 1 bit: read data valid, arriving any number of cycles (including 0) after imem_req rises.
REQ-008 Port imem_rdata, input, 32 bits: read data, sampled when imem_req and imem_ack are both high.
REQ-009 Port redirect_valid, input, 1 bit: taken branch or jump from the branch-condition stage.
REQ-010 Port redirect_pc, input, 32 bits: new fetch target.
REQ-011 Port instr_valid, output, 1 bit: FIFO head is valid for the decoder.
REQ-012 Port instr_ready, input, 1 bit: decoder accepts the head.
REQ-013 Port instruction, output, 32 bits: head instruction word, driving the decoder's instruction input.
REQ-014 Port instr_pc, output, 32 bits: address of the head instruction.

Function
REQ-015 fetch_pc SHALL be a 32-bit register; imem_addr SHALL equal fetch_pc at all times.
REQ-016 The FSM SHALL have three states: IDLE (no request outstanding), WAIT (request outstanding), and DISCARD (request outstanding whose response is dropped).
REQ-017 imem_req SHALL be high exactly in WAIT and DISCARD, and low in IDLE.
REQ-018 In IDLE with no redirect, the FSM SHALL go to WAIT when FIFO count < DEPTH; otherwise it SHALL remain in IDLE.
REQ-019 Only one request SHALL be outstanding at a time, and imem_addr SHALL stay stable while in WAIT.
REQ-020 In WAIT, an ack SHALL push {fetch_pc, imem_rdata} into the FIFO, set fetch_pc to fetch_pc+4 (mod 2^32, so 32'hFFFFFFFC wraps to 0), and go to IDLE.
REQ-021 Fetch-to-FIFO latency SHALL be 1 cycle in IDLE, plus the ack wait, plus 1 cycle; the instruction SHALL be visible on the cycle after the ack edge.
REQ-022 instr_valid SHALL equal (count != 0); instruction and instr_pc SHALL show the head entry, or 0 when the FIFO is empty.
REQ-023 A pop SHALL occur when instr_valid and instr_ready are both high; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-024 The request issue rule SHALL guarantee FIFO room at ack time; an overflow push SHALL never occur.
REQ-025 Redirect SHALL take priority over push and pop: the FIFO SHALL be flushed (count to 0, pop ignored) and fetch_pc set to {redirect_pc[31:2], 2'b00}.
REQ-026 Redirect in IDLE SHALL leave the FSM in IDLE.
REQ-027 Redirect in WAIT without ack SHALL move the FSM to DISCARD.
REQ-028 Redirect in WAIT with ack in the same cycle SHALL drop the data and move the FSM to IDLE.
REQ-029 In DISCARD, an ack SHALL drop the data and move the FSM to IDLE with fetch_pc unchanged.
REQ-030 A redirect while in DISCARD SHALL update fetch_pc and leave the FSM in DISCARD.
REQ-031 After a redirect, instr_valid SHALL be low on the following cycle.
REQ-032 The block SHALL contain no latches: every combinational output SHALL be assigned on all paths, with default cases.

Reset
REQ-033 While reset is high, the block SHALL immediately force: state IDLE, fetch_pc RESET_PC, count 0, imem_req 0, imem_addr RESET_PC, instr_valid 0, instruction 0, instr_pc 0.
REQ-034 An ack arriving during reset SHALL be ignored; an assertion mid-WAIT SHALL abandon the request.
REQ-035 The first imem_req SHALL rise on the first clk edge after reset deasserts.

Verification
REQ-036 Stream test: after reset, with ack 1 cycle after each req, rdata = 32'h0000000A+addr, and instr_ready=1 -> instr_pc sequence 0,4,8,12 with matching instruction words, in order.
REQ-037 Full test: with instr_ready=0 and 4 acks accepted -> instr_valid=1, head instr_pc=0, imem_req low; one pop -> a new request to address 16 issues.
REQ-038 Redirect in WAIT: redirect to 32'h00000103 while a request is outstanding -> that ack's data is never seen; the next request goes to 32'h00000100 and the FIFO is empty the cycle after the redirect.
REQ-039 Redirect with same-cycle ack and pop on a 2-entry FIFO -> count 0, the FSM returns to IDLE, and the next fetch is to the redirect target.
REQ-040 Wrap test: redirect to 32'hFFFFFFFC -> instr_pc sequence FFFFFFFC then 00000000.
REQ-041 Reset asserted mid-WAIT -> imem_req drops immediately; after release, fetch restarts at RESET_PC.
